// File: rtl/press_arb_pkg.sv
// Shared types and the round-robin selection helper for the press event arbiter.
package press_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    localparam int DB_CYCLES_DEFAULT = 4;
    localparam int MAX_N             = 32;

    // First set bit scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
    function automatic logic [4:0] rr_pick(
        input logic [MAX_N-1:0] pending,
        input logic [4:0]       ptr,
        input int unsigned      n
    );
        logic [4:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = 5'd0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_N; off++) begin
            idx = (int'(ptr) + off) % n;
            if (!found && (off < n) && pending[idx]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/press_event_arbiter_input_debounce.sv
// One input channel: 2-flop synchroniser, stability-count debounce and rising-edge detect.
module input_debounce
    import press_arb_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_rise
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db_state;
    logic [CW-1:0] r_cnt;
    logic          w_fire;

    // The debounced level flips on the edge where the counter saturates.
    assign w_fire = (r_sync2 != r_db_state) && (r_cnt == CW'(DB_CYCLES - 1));
    assign o_rise = w_fire & r_sync2;

    // Synchroniser and debounce counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_state <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db_state) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                r_db_state <= r_sync2;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/press_event_arbiter.sv
// Debounces N raw press inputs, latches sticky pending flags and serialises
// them round-robin onto a single registered valid/ready event stream.
module press_event_arbiter
    import press_arb_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int DB_CYCLES = DB_CYCLES_DEFAULT,
    localparam int W         = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_press,
    input  logic         i_ev_ready,
    output logic         o_ev_valid,
    output logic [W-1:0] o_ev_id,
    output logic [N-1:0] o_pending,
    output logic         o_overrun
);

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic         r_ev_valid;
    logic         w_ev_valid_nxt;
    logic [W-1:0] r_ev_id;
    logic [W-1:0] w_ev_id_nxt;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_nxt;
    logic [W-1:0] w_pick;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pending_nxt;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_clear;
    logic         r_overrun;
    logic         w_overrun_nxt;

    for (genvar g = 0; g < N; g++) begin : g_db
        input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_press[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_pick = W'(rr_pick(MAX_N'(r_pending), 5'(r_ptr), N));

    // Pending bookkeeping: a same-edge rise beats the accept clear, so nothing is lost.
    always_comb begin
        w_clear = '0;
        if ((r_state == ARB_OFFER) && i_ev_ready) begin
            w_clear = {{(N-1){1'b0}}, 1'b1} << r_ev_id;
        end else begin
            w_clear = '0;
        end
        w_pending_nxt = (r_pending & ~w_clear) | w_rise;
        w_overrun_nxt = |(w_rise & r_pending & ~w_clear);
    end

    // Arbiter next-state and next output values.
    always_comb begin
        w_state_nxt    = r_state;
        w_ev_valid_nxt = r_ev_valid;
        w_ev_id_nxt    = r_ev_id;
        w_ptr_nxt      = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt    = ARB_OFFER;
                    w_ev_valid_nxt = 1'b1;
                    w_ev_id_nxt    = w_pick;
                end else begin
                    w_ev_valid_nxt = 1'b0;
                end
            end
            ARB_OFFER: begin
                if (i_ev_ready) begin
                    w_state_nxt    = ARB_IDLE;
                    w_ev_valid_nxt = 1'b0;
                    w_ptr_nxt      = (r_ev_id == W'(N - 1)) ? W'(0) : r_ev_id + W'(1);
                end else begin
                    w_ev_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ARB_IDLE;
                w_ev_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ARB_IDLE;
            r_ev_valid <= 1'b0;
            r_ev_id    <= '0;
            r_ptr      <= '0;
            r_pending  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ev_valid <= w_ev_valid_nxt;
            r_ev_id    <= w_ev_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign o_ev_valid = r_ev_valid;
    assign o_ev_id    = r_ev_id;
    assign o_pending  = r_pending;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_press_event_arbiter.sv
// Directed bench for press_event_arbiter: a default N=4 instance and an N=3 instance for wrap-around.
module tb_press_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] press;
    logic       ready;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic [3:0] pending;
    logic       overrun;

    logic [2:0] press3;
    logic       ready3;
    logic       ev_valid3;
    logic [1:0] ev_id3;
    logic [2:0] pending3;
    logic       overrun3;

    int checks = 0;
    int errors = 0;

    press_event_arbiter #(.N(4), .DB_CYCLES(4)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_press    (press),
        .i_ev_ready (ready),
        .o_ev_valid (ev_valid),
        .o_ev_id    (ev_id),
        .o_pending  (pending),
        .o_overrun  (overrun)
    );

    press_event_arbiter #(.N(3), .DB_CYCLES(4)) dut3 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_press    (press3),
        .i_ev_ready (ready3),
        .o_ev_valid (ev_valid3),
        .o_ev_id    (ev_id3),
        .o_pending  (pending3),
        .o_overrun  (overrun3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n cycles, reporting whether ev_valid or overrun of the N=4 instance was ever seen high.
    task automatic watch(input int n, output logic seen_valid, output logic seen_ovr);
        seen_valid = 1'b0;
        seen_ovr   = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1);
            seen_valid = seen_valid | ev_valid;
            seen_ovr   = seen_ovr | overrun;
        end
    endtask

    initial begin
        logic sv;
        logic so;
        reset  = 1'b1;
        press  = 4'b0000;
        ready  = 1'b0;
        press3 = 3'b000;
        ready3 = 1'b0;
        step(2);
        chk("rst_valid",   ev_valid, 1'b0);
        chk("rst_id",      ev_id,    2'd0);
        chk("rst_pending", pending,  4'b0000);
        chk("rst_overrun", overrun,  1'b0);

        // 1: single press, latency DB_CYCLES+3
        reset = 1'b0;
        press = 4'b0001;
        ready = 1'b1;
        step(6);
        chk("t1_valid_e6",   ev_valid, 1'b0);
        chk("t1_pending_e6", pending,  4'b0001);
        step(1);
        chk("t1_valid_e7", ev_valid, 1'b1);
        chk("t1_id_e7",    ev_id,    2'd0);
        step(1);
        chk("t1_valid_e8",   ev_valid, 1'b0);
        chk("t1_pending_e8", pending,  4'b0000);
        watch(10, sv, so);
        chk("t1_held_once", sv, 1'b0);
        press = 4'b0000;
        step(8);

        // 2: 3-cycle glitch ignored, 4-cycle press accepted
        press = 4'b0010;
        step(3);
        press = 4'b0000;
        watch(10, sv, so);
        chk("t2_glitch_valid",   sv,      1'b0);
        chk("t2_glitch_pending", pending, 4'b0000);
        press = 4'b0010;
        step(4);
        press = 4'b0000;
        step(2);
        chk("t2_pending", pending, 4'b0010);
        step(1);
        chk("t2_valid", ev_valid, 1'b1);
        chk("t2_id",    ev_id,    2'd1);
        step(1);
        chk("t2_done", ev_valid, 1'b0);
        step(8);

        // 3: simultaneous rises served round-robin with an idle cycle between
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        press = 4'b1101;
        step(6);
        chk("t3_pending", pending, 4'b1101);
        step(1);
        chk("t3_a_valid", ev_valid, 1'b1);
        chk("t3_a_id",    ev_id,    2'd0);
        step(1);
        chk("t3_a_idle", ev_valid, 1'b0);
        step(1);
        chk("t3_b_valid", ev_valid, 1'b1);
        chk("t3_b_id",    ev_id,    2'd2);
        step(1);
        chk("t3_b_idle", ev_valid, 1'b0);
        step(1);
        chk("t3_c_valid", ev_valid, 1'b1);
        chk("t3_c_id",    ev_id,    2'd3);
        step(1);
        chk("t3_c_idle",  ev_valid, 1'b0);
        chk("t3_c_empty", pending,  4'b0000);
        press = 4'b0000;
        step(8);
        press = 4'b1001;
        step(7);
        chk("t3_d_id", ev_id, 2'd0);
        step(2);
        chk("t3_e_valid", ev_valid, 1'b1);
        chk("t3_e_id",    ev_id,    2'd3);
        press = 4'b0000;
        step(8);

        // 4: stalled offer, re-press merges with an overrun pulse
        ready = 1'b0;
        press = 4'b0100;
        step(7);
        chk("t4_valid", ev_valid, 1'b1);
        chk("t4_id",    ev_id,    2'd2);
        press = 4'b0000;
        step(8);
        press = 4'b0100;
        step(5);
        chk("t4_ovr_before", overrun, 1'b0);
        step(1);
        chk("t4_ovr_pulse", overrun, 1'b1);
        step(1);
        chk("t4_ovr_after", overrun,  1'b0);
        chk("t4_hold_valid", ev_valid, 1'b1);
        chk("t4_hold_id",   ev_id,    2'd2);
        chk("t4_hold_pend", pending,  4'b0100);
        ready = 1'b1;
        step(1);
        chk("t4_acc_valid", ev_valid, 1'b0);
        chk("t4_acc_pend",  pending,  4'b0000);
        watch(4, sv, so);
        chk("t4_single", sv, 1'b0);
        press = 4'b0000;
        step(8);

        // 5: reset during an offer with the input held
        ready = 1'b0;
        press = 4'b0010;
        step(7);
        chk("t5_offer_id", ev_id, 2'd1);
        reset = 1'b1;
        step(1);
        chk("t5_rst_valid", ev_valid, 1'b0);
        chk("t5_rst_pend",  pending,  4'b0000);
        reset = 1'b0;
        ready = 1'b1;
        step(6);
        chk("t5_e6_valid", ev_valid, 1'b0);
        step(1);
        chk("t5_e7_valid", ev_valid, 1'b1);
        chk("t5_e7_id",    ev_id,    2'd1);
        step(1);
        watch(6, sv, so);
        chk("t5_single", sv, 1'b0);
        chk("t5_no_ovr", so, 1'b0);
        press = 4'b0000;

        // 6: N=3 wrap-around and rise on the accepted id at the accept edge
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        press3 = 3'b010;
        ready3 = 1'b1;
        step(7);
        chk("t6_first_id", ev_id3, 2'd1);
        step(1);
        ready3 = 1'b0;
        press3 = 3'b111;
        step(6);
        chk("t6_pending", pending3, 3'b101);
        step(1);
        chk("t6_a_valid", ev_valid3, 1'b1);
        chk("t6_a_id",    ev_id3,    2'd2);
        ready3 = 1'b1;
        step(1);
        chk("t6_a_acc", pending3, 3'b001);
        ready3 = 1'b0;
        step(1);
        chk("t6_b_valid", ev_valid3, 1'b1);
        chk("t6_b_id",    ev_id3,    2'd0);
        press3 = 3'b110;
        step(8);
        press3 = 3'b111;
        step(5);
        ready3 = 1'b1;
        step(1);
        chk("t6_merge_valid", ev_valid3, 1'b0);
        chk("t6_merge_pend",  pending3,  3'b001);
        chk("t6_merge_ovr",   overrun3,  1'b0);
        step(1);
        chk("t6_re_valid", ev_valid3, 1'b1);
        chk("t6_re_id",    ev_id3,    2'd0);
        chk("t6_re_ovr",   overrun3,  1'b0);
        step(1);
        chk("t6_end_pend", pending3, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
